// File: rtl/intrusion_alarm_ctrl.sv
// Intrusion alarm sequencer: arm/disarm FSM with a two-digit BCD countdown
// stepped by an external 1 Hz tick; drives siren, armed flag and display digits.
module intrusion_alarm_ctrl #(
  parameter int EXIT_DELAY  = 30,
  parameter int ENTRY_DELAY = 15,
  parameter int ALARM_TIME  = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       arm_req,
  input  logic       disarm_req,
  input  logic       door_open,
  input  logic       window_open,
  output logic [2:0] state,
  output logic       armed,
  output logic       siren,
  output logic [3:0] count_tens,
  output logic [3:0] count_ones,
  output logic       arm_fault
);

  // state    | meaning
  // DISARMED | idle, count 00, arm requests checked against sensors
  // EXIT     | exit delay running, sensors ignored
  // ARMED    | watching sensors, count 00
  // ENTRY    | entry delay running after door opened
  // ALARM    | siren on for ALARM_TIME seconds
  localparam logic [2:0] S_DISARMED = 3'd0;
  localparam logic [2:0] S_EXIT     = 3'd1;
  localparam logic [2:0] S_ARMED    = 3'd2;
  localparam logic [2:0] S_ENTRY    = 3'd3;
  localparam logic [2:0] S_ALARM    = 3'd4;

  localparam logic [3:0] EXIT_TENS  = 4'(EXIT_DELAY / 10);
  localparam logic [3:0] EXIT_ONES  = 4'(EXIT_DELAY % 10);
  localparam logic [3:0] ENTRY_TENS = 4'(ENTRY_DELAY / 10);
  localparam logic [3:0] ENTRY_ONES = 4'(ENTRY_DELAY % 10);
  localparam logic [3:0] ALARM_TENS = 4'(ALARM_TIME / 10);
  localparam logic [3:0] ALARM_ONES = 4'(ALARM_TIME % 10);

  logic [2:0] state_q, state_nxt;
  logic [3:0] tens_q, tens_nxt;
  logic [3:0] ones_q, ones_nxt;
  logic       fault_q, fault_nxt;
  logic       armed_q, armed_nxt;
  logic       siren_q, siren_nxt;
  logic       cnt_load;
  logic       cnt_zero;
  logic [3:0] dec_tens, dec_ones;

  assign cnt_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

  // BCD borrow: ones wraps 0->9 and takes one from tens
  always_comb begin
    if (ones_q != 4'd0) begin
      dec_tens = tens_q;
      dec_ones = ones_q - 4'd1;
    end else begin
      dec_tens = tens_q - 4'd1;
      dec_ones = 4'd9;
    end
  end

  // state register (all outputs are registered here)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_DISARMED;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      fault_q <= 1'b0;
      armed_q <= 1'b0;
      siren_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      tens_q  <= tens_nxt;
      ones_q  <= ones_nxt;
      fault_q <= fault_nxt;
      armed_q <= armed_nxt;
      siren_q <= siren_nxt;
    end
  end

  // next-state and countdown
  always_comb begin
    state_nxt = state_q;
    tens_nxt  = tens_q;
    ones_nxt  = ones_q;
    fault_nxt = 1'b0;
    cnt_load  = 1'b0;
    case (state_q)
      S_DISARMED: begin
        tens_nxt = 4'd0;
        ones_nxt = 4'd0;
        cnt_load = 1'b1;
        if (arm_req) begin
          if (!door_open && !window_open) begin
            state_nxt = S_EXIT;
            tens_nxt  = EXIT_TENS;
            ones_nxt  = EXIT_ONES;
          end else begin
            fault_nxt = 1'b1;
          end
        end
      end
      S_EXIT: begin
        if (disarm_req) begin
          state_nxt = S_DISARMED;
          tens_nxt  = 4'd0;
          ones_nxt  = 4'd0;
          cnt_load  = 1'b1;
        end else if (tick) begin
          if (cnt_zero) begin
            state_nxt = S_ARMED;
            cnt_load  = 1'b1;
          end else begin
            tens_nxt = dec_tens;
            ones_nxt = dec_ones;
          end
        end
      end
      S_ARMED: begin
        tens_nxt = 4'd0;
        ones_nxt = 4'd0;
        cnt_load = 1'b1;
        if (disarm_req) begin
          state_nxt = S_DISARMED;
        end else if (window_open) begin
          state_nxt = S_ALARM;
          tens_nxt  = ALARM_TENS;
          ones_nxt  = ALARM_ONES;
        end else if (door_open) begin
          state_nxt = S_ENTRY;
          tens_nxt  = ENTRY_TENS;
          ones_nxt  = ENTRY_ONES;
        end
      end
      S_ENTRY: begin
        // door level is expected to stay open here and must not restart the delay
        if (disarm_req) begin
          state_nxt = S_DISARMED;
          tens_nxt  = 4'd0;
          ones_nxt  = 4'd0;
          cnt_load  = 1'b1;
        end else if (window_open || (tick && cnt_zero)) begin
          state_nxt = S_ALARM;
          tens_nxt  = ALARM_TENS;
          ones_nxt  = ALARM_ONES;
          cnt_load  = 1'b1;
        end else if (tick) begin
          tens_nxt = dec_tens;
          ones_nxt = dec_ones;
        end
      end
      S_ALARM: begin
        // sensors neither reload nor stall the siren timer
        if (disarm_req) begin
          state_nxt = S_DISARMED;
          tens_nxt  = 4'd0;
          ones_nxt  = 4'd0;
          cnt_load  = 1'b1;
        end else if (tick) begin
          if (cnt_zero) begin
            state_nxt = S_ARMED;
            cnt_load  = 1'b1;
          end else begin
            tens_nxt = dec_tens;
            ones_nxt = dec_ones;
          end
        end
      end
      default: begin
        state_nxt = S_DISARMED;
        tens_nxt  = 4'd0;
        ones_nxt  = 4'd0;
        cnt_load  = 1'b1;
      end
    endcase
  end

  // outputs decoded from the next state so they move together with state
  always_comb begin
    armed_nxt = (state_nxt != S_DISARMED);
    siren_nxt = (state_nxt == S_ALARM);
  end

  assign state      = state_q;
  assign armed      = armed_q;
  assign siren      = siren_q;
  assign count_tens = tens_q;
  assign count_ones = ones_q;
  assign arm_fault  = fault_q;

`ifndef SYNTHESIS
  logic       load_q;
  logic [2:0] cov_stage;

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] != 4'd0) bcd_dec = {v[7:4], v[3:0] - 4'd1};
    else                bcd_dec = {v[7:4] - 4'd1, 4'd9};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) load_q <= 1'b1;
    else       load_q <= cnt_load;
  end

  // tracks DISARMED->EXIT->ARMED->ENTRY->ALARM->ARMED
  always_ff @(posedge clk) begin
    if (reset) begin
      cov_stage <= 3'd0;
    end else begin
      case (cov_stage)
        3'd0: if (state_q == S_DISARMED) cov_stage <= 3'd1;
        3'd1: if (state_q == S_EXIT) cov_stage <= 3'd2;
              else if (state_q != S_DISARMED) cov_stage <= 3'd0;
        3'd2: if (state_q == S_ARMED) cov_stage <= 3'd3;
              else if (state_q != S_EXIT) cov_stage <= 3'd0;
        3'd3: if (state_q == S_ENTRY) cov_stage <= 3'd4;
              else if (state_q != S_ARMED) cov_stage <= 3'd0;
        3'd4: if (state_q == S_ALARM) cov_stage <= 3'd5;
              else if (state_q != S_ENTRY) cov_stage <= 3'd0;
        3'd5: if (state_q == S_ARMED) cov_stage <= 3'd6;
              else if (state_q != S_ALARM) cov_stage <= 3'd0;
        default: cov_stage <= 3'd6;
      endcase
    end
  end

  a_digits: assert property (@(posedge clk) disable iff (reset)
    (tens_q <= 4'd9) && (ones_q <= 4'd9));
  a_siren: assert property (@(posedge clk) disable iff (reset)
    siren_q |-> (state_q == S_ALARM));
  a_idle_zero: assert property (@(posedge clk) disable iff (reset)
    ((state_q == S_DISARMED) || (state_q == S_ARMED)) |-> cnt_zero);
  a_dec: assert property (@(posedge clk) disable iff (reset)
    (!load_q && ({tens_q, ones_q} != $past({tens_q, ones_q})))
      |-> ({tens_q, ones_q} == bcd_dec($past({tens_q, ones_q}))));
  c_full_seq: cover property (@(posedge clk) cov_stage == 3'd6);
`endif

endmodule

// File: tb/tb_intrusion_alarm_ctrl.sv
// Directed bench for intrusion_alarm_ctrl with EXIT_DELAY=3, ENTRY_DELAY=15,
// ALARM_TIME=60; expected values are worked out by hand from the behaviour.
module tb_intrusion_alarm_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       arm_req = 1'b0;
  logic       disarm_req = 1'b0;
  logic       door_open = 1'b0;
  logic       window_open = 1'b0;
  logic [2:0] state;
  logic       armed;
  logic       siren;
  logic [3:0] count_tens;
  logic [3:0] count_ones;
  logic       arm_fault;

  int n_total = 0;
  int n_pass  = 0;

  intrusion_alarm_ctrl #(
    .EXIT_DELAY (3),
    .ENTRY_DELAY(15),
    .ALARM_TIME (60)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .arm_req    (arm_req),
    .disarm_req (disarm_req),
    .door_open  (door_open),
    .window_open(window_open),
    .state      (state),
    .armed      (armed),
    .siren      (siren),
    .count_tens (count_tens),
    .count_ones (count_ones),
    .arm_fault  (arm_fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // compares state, armed, siren and the count (as decimal tens*10+ones)
  task automatic chk_all(input string tag, input int st, input int ar,
                         input int si, input int cnt);
    chk({tag, ".state"}, 16'(state), 16'(st));
    chk({tag, ".armed"}, 16'(armed), 16'(ar));
    chk({tag, ".siren"}, 16'(siren), 16'(si));
    chk({tag, ".tens"},  16'(count_tens), 16'(cnt / 10));
    chk({tag, ".ones"},  16'(count_ones), 16'(cnt % 10));
  endtask

  task automatic arm_and_settle();
    arm_req = 1'b1;
    step();
    arm_req = 1'b0;
    ticks(4);
  endtask

  initial begin
    // reset
    reset = 1'b1;
    step();
    step();
    chk_all("reset", 0, 0, 0, 0);
    chk("reset.fault", 16'(arm_fault), 16'd0);
    reset = 1'b0;

    // arm rejected with window open: one-cycle fault
    window_open = 1'b1;
    arm_req = 1'b1;
    step();
    arm_req = 1'b0;
    chk_all("fault", 0, 0, 0, 0);
    chk("fault.pulse", 16'(arm_fault), 16'd1);
    step();
    chk("fault.clear", 16'(arm_fault), 16'd0);
    chk("fault.state", 16'(state), 16'd0);
    window_open = 1'b0;

    // exit delay 3: 03,02,01,00 then ARMED on 4th tick
    arm_req = 1'b1;
    step();
    arm_req = 1'b0;
    chk_all("exit.load", 1, 1, 0, 3);
    ticks(1);
    chk_all("exit.t1", 1, 1, 0, 2);
    step(); step(); step();
    chk_all("exit.hold", 1, 1, 0, 2);
    ticks(1);
    chk_all("exit.t2", 1, 1, 0, 1);
    ticks(1);
    chk_all("exit.t3", 1, 1, 0, 0);
    ticks(1);
    chk_all("exit.t4", 2, 1, 0, 0);

    // entry delay, decade borrow, then disarm+tick at 07
    door_open = 1'b1;
    step();
    chk_all("entry.load", 3, 1, 0, 15);
    ticks(5);
    chk_all("entry.10", 3, 1, 0, 10);
    ticks(1);
    chk_all("entry.borrow", 3, 1, 0, 9);
    ticks(2);
    chk_all("entry.07", 3, 1, 0, 7);
    tick = 1'b1;
    disarm_req = 1'b1;
    step();
    tick = 1'b0;
    disarm_req = 1'b0;
    chk_all("entry.disarm", 0, 0, 0, 0);
    door_open = 1'b0;

    // entry timeout into alarm, then reset at 42
    arm_and_settle();
    chk_all("rearm", 2, 1, 0, 0);
    door_open = 1'b1;
    step();
    door_open = 1'b0;
    chk_all("entry2.load", 3, 1, 0, 15);
    ticks(15);
    chk_all("entry2.00", 3, 1, 0, 0);
    ticks(1);
    chk_all("entry2.timeout", 4, 1, 1, 60);
    window_open = 1'b1;
    step();
    window_open = 1'b0;
    chk_all("alarm.noreload", 4, 1, 1, 60);
    ticks(18);
    chk_all("alarm.42", 4, 1, 1, 42);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_all("alarm.reset", 0, 0, 0, 0);

    // window trip, full 61-tick siren, retrigger, disarm
    arm_and_settle();
    window_open = 1'b1;
    step();
    chk_all("win.alarm", 4, 1, 1, 60);
    ticks(60);
    chk_all("win.00", 4, 1, 1, 0);
    ticks(1);
    chk_all("win.timeout", 2, 1, 0, 0);
    step();
    chk_all("win.retrigger", 4, 1, 1, 60);
    disarm_req = 1'b1;
    step();
    disarm_req = 1'b0;
    chk_all("win.disarm", 0, 0, 0, 0);
    window_open = 1'b0;

    // disarm ignored when idle; arm+disarm together arms; sensors ignored in EXIT
    disarm_req = 1'b1;
    step();
    chk_all("idle.disarm", 0, 0, 0, 0);
    arm_req = 1'b1;
    step();
    arm_req = 1'b0;
    disarm_req = 1'b0;
    chk_all("both.arm", 1, 1, 0, 3);
    window_open = 1'b1;
    door_open = 1'b1;
    arm_req = 1'b1;
    ticks(1);
    arm_req = 1'b0;
    chk_all("exit.sensors", 1, 1, 0, 2);
    window_open = 1'b0;
    door_open = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end
endmodule
